// File: rtl/game_pkg.sv
// Shared types and helpers for the game-flow controller.
// The lives feature is enabled by defining GAME_LEVEL_FSM_LIVES_EN.
package game_pkg;

    typedef enum logic [2:0] {
        START, LOAD, PLAY, TRANSITION, RESPAWN, VICTORY, OVER
    } game_state_t;

    localparam logic [2:0] GS_START      = 3'd0;
    localparam logic [2:0] GS_PLAY       = 3'd1;
    localparam logic [2:0] GS_TRANSITION = 3'd2;
    localparam logic [2:0] GS_RESPAWN    = 3'd3;
    localparam logic [2:0] GS_VICTORY    = 3'd4;
    localparam logic [2:0] GS_OVER       = 3'd5;

    // min(base + idx*step, cap), computed wide so it cannot wrap
    function automatic int sat_add(int base, int step, int idx, int cap);
        longint sum;
        sum = longint'(base) + longint'(step) * longint'(idx);
        return (sum > longint'(cap)) ? cap : int'(sum);
    endfunction

    // LOAD is reported as PLAY: the drawing side starts the new level there
    function automatic logic [2:0] gs_code(game_state_t s);
        logic [2:0] c;
        case (s)
            START:      c = GS_START;
            LOAD:       c = GS_PLAY;
            PLAY:       c = GS_PLAY;
            TRANSITION: c = GS_TRANSITION;
            RESPAWN:    c = GS_RESPAWN;
            VICTORY:    c = GS_VICTORY;
            OVER:       c = GS_OVER;
            default:    c = GS_START;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Counts slowClk ticks toward a target; done pulses on the target-th tick
// and the count wraps to zero. Held at zero while clear_i is high.
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         tick_i,
    input  logic [W-1:0] target_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    assign done_o = tick_i && !clear_i && (({1'b0, count_q} + 1'b1) == {1'b0, target_i});

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (tick_i) begin
            count_q <= done_o ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/game_level_fsm.sv
// Parametrised game-flow controller: start, N levels, transitions, respawn,
// victory and game over. Lives/respawn enabled by GAME_LEVEL_FSM_LIVES_EN.
module game_level_fsm
    import game_pkg::*;
#(
    parameter int NUM_LEVELS       = 4,
    parameter int MAX_ENEMIES      = 4,
    parameter int ENEMIES_BASE     = 2,
    parameter int ENEMIES_STEP     = 1,
    parameter int SPEED_BASE       = 120,
    parameter int SPEED_STEP       = 120,
    parameter int TREE_BASE        = 8,
    parameter int TREE_STEP        = 0,
    parameter int TRANSITION_TICKS = 120,
    parameter int RESPAWN_TICKS    = 60,
    parameter int LIVES            = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            playerDead,
    input  logic [MAX_ENEMIES-1:0]          shotEnemyCollision,
    input  logic                            slowClk,
    input  logic                            playerTrigger,
    output logic                            pause,
    output logic                            start_screen,
    output logic                            death_screen,
    output logic                            victory_screen,
    output logic [2:0]                      currentGameState,
    output logic [$clog2(NUM_LEVELS):0]     level,
    output logic [$clog2(MAX_ENEMIES):0]    enemiesRemaining,
    output logic [2:0]                      livesLeft,
    output logic [10:0]                     curEnemySpeed,
    output logic [3:0]                      tree_count,
    output logic                            newLevel
);

    localparam int LW = $clog2(NUM_LEVELS) + 1;
    localparam int EW = $clog2(MAX_ENEMIES) + 1;
    localparam int TW = $clog2((TRANSITION_TICKS > RESPAWN_TICKS ? TRANSITION_TICKS : RESPAWN_TICKS) + 1);

    game_state_t   state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [EW-1:0] enem_q, enem_d;
    logic          trig_q;
    logic          trig_rise;
    logic [EW-1:0] kills;
    logic [EW-1:0] lvl_enemies;
    logic          tmr_run, tmr_done;
    logic [TW-1:0] tmr_target;

    logic          pause_q, start_q, death_q, vic_q, newlvl_q;
    logic [2:0]    gs_q;

    assign trig_rise = playerTrigger & ~trig_q;

    always_comb begin
        kills = '0;
        for (int i = 0; i < MAX_ENEMIES; i++) begin
            kills = kills + EW'(shotEnemyCollision[i]);
        end
    end

    assign lvl_enemies   = EW'(sat_add(ENEMIES_BASE, ENEMIES_STEP, int'(level_q), MAX_ENEMIES));
    assign curEnemySpeed = 11'(sat_add(SPEED_BASE, SPEED_STEP, int'(level_q), 2047));
    assign tree_count    = 4'(sat_add(TREE_BASE, TREE_STEP, int'(level_q), 15));

`ifdef GAME_LEVEL_FSM_LIVES_EN
    logic [2:0] lives_q, lives_d;

    assign tmr_run    = (state_q == TRANSITION) || (state_q == RESPAWN);
    assign tmr_target = (state_q == RESPAWN) ? TW'(RESPAWN_TICKS) : TW'(TRANSITION_TICKS);
    assign livesLeft  = lives_q;
`else
    assign tmr_run    = (state_q == TRANSITION);
    assign tmr_target = TW'(TRANSITION_TICKS);
    assign livesLeft  = 3'd1;
`endif

    // Timer is held clear outside the timed states, so it is zero on every entry
    tick_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (~tmr_run),
        .tick_i   (slowClk),
        .target_i (tmr_target),
        .done_o   (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        enem_d  = enem_q;
`ifdef GAME_LEVEL_FSM_LIVES_EN
        lives_d = lives_q;
`endif
        unique case (state_q)
            START: begin
                if (trig_rise) begin
                    level_d = '0;
`ifdef GAME_LEVEL_FSM_LIVES_EN
                    lives_d = 3'(LIVES);
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                enem_d  = lvl_enemies;
                state_d = PLAY;
            end
            PLAY: begin
                // Clearing the level wins over a simultaneous death
                if (kills >= enem_q) begin
                    enem_d  = '0;
                    state_d = (level_q == LW'(NUM_LEVELS - 1)) ? VICTORY : TRANSITION;
                end else begin
                    enem_d = enem_q - kills;
                    if (playerDead) begin
`ifdef GAME_LEVEL_FSM_LIVES_EN
                        lives_d = lives_q - 3'd1;
                        state_d = (lives_q == 3'd1) ? OVER : RESPAWN;
`else
                        state_d = OVER;
`endif
                    end
                end
            end
            TRANSITION: begin
                if (tmr_done) begin
                    level_d = level_q + 1'b1;
                    state_d = LOAD;
                end
            end
`ifdef GAME_LEVEL_FSM_LIVES_EN
            RESPAWN: begin
                if (tmr_done) state_d = PLAY;
            end
`endif
            VICTORY, OVER: begin
                if (trig_rise) state_d = START;
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= START;
            level_q  <= '0;
            enem_q   <= '0;
            trig_q   <= 1'b0;
            pause_q  <= 1'b1;
            start_q  <= 1'b1;
            death_q  <= 1'b0;
            vic_q    <= 1'b0;
            newlvl_q <= 1'b0;
            gs_q     <= GS_START;
`ifdef GAME_LEVEL_FSM_LIVES_EN
            lives_q  <= 3'(LIVES);
`endif
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            enem_q   <= enem_d;
            trig_q   <= playerTrigger;
            pause_q  <= (state_d != PLAY);
            start_q  <= (state_d == START);
            death_q  <= (state_d == OVER);
            vic_q    <= (state_d == VICTORY);
            newlvl_q <= (state_d == LOAD);
            gs_q     <= gs_code(state_d);
`ifdef GAME_LEVEL_FSM_LIVES_EN
            lives_q  <= lives_d;
`endif
        end
    end

    assign pause            = pause_q;
    assign start_screen     = start_q;
    assign death_screen     = death_q;
    assign victory_screen   = vic_q;
    assign newLevel         = newlvl_q;
    assign currentGameState = gs_q;
    assign level            = level_q;
    assign enemiesRemaining = enem_q;

endmodule

// File: tb/tb_game_level_fsm.sv
// Self-checking bench for game_level_fsm: cycle model plus directed literal checks.
// Honours GAME_LEVEL_FSM_LIVES_EN when the build defines it.
module tb_game_level_fsm;

    localparam int NL = 4;
    localparam int ME = 4;
`ifdef GAME_LEVEL_FSM_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif

    logic          clk = 1'b0, reset = 1'b1, playerDead = 1'b0, slowClk = 1'b0, playerTrigger = 1'b0;
    logic [ME-1:0] shot = '0;
    logic          pause, start_screen, death_screen, victory_screen, newLevel;
    logic [2:0]    currentGameState, livesLeft, level, enemiesRemaining;
    logic [10:0]   curEnemySpeed;
    logic [3:0]    tree_count;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;

    // Model: phase 0 start,1 play,2 transition,3 respawn,4 victory,5 over; m_load = level-load cycle
    int m_phase = 0, m_level = 0, m_rem = 0, m_lives = 3, m_ticks = 0;
    bit m_load = 1'b0, m_prev = 1'b0;

    game_level_fsm dut (
        .clk(clk), .reset(reset), .playerDead(playerDead), .shotEnemyCollision(shot),
        .slowClk(slowClk), .playerTrigger(playerTrigger), .pause(pause),
        .start_screen(start_screen), .death_screen(death_screen), .victory_screen(victory_screen),
        .currentGameState(currentGameState), .level(level), .enemiesRemaining(enemiesRemaining),
        .livesLeft(livesLeft), .curEnemySpeed(curEnemySpeed), .tree_count(tree_count),
        .newLevel(newLevel)
    );

    always #5 clk = ~clk;

    function automatic int enemies_for(int l);
        return (2 + l > 4) ? 4 : 2 + l;
    endfunction

    function automatic int speed_for(int l);
        return (120 + 120 * l > 2047) ? 2047 : 120 + 120 * l;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        int  k;
        bit  rise;
        rise   = playerTrigger && !m_prev;
        m_prev = playerTrigger;
        k      = $countones(shot);
        if (reset) begin
            m_phase = 0; m_load = 0; m_level = 0; m_rem = 0; m_lives = 3; m_ticks = 0; m_prev = 0;
        end else if (m_load) begin
            m_load = 0;
            m_rem  = enemies_for(m_level);
        end else begin
            case (m_phase)
                0: if (rise) begin m_level = 0; m_lives = 3; m_load = 1; m_phase = 1; end
                1: begin
                    if (k >= m_rem) begin
                        m_rem = 0; m_ticks = 0;
                        m_phase = (m_level == NL - 1) ? 4 : 2;
                    end else begin
                        m_rem = m_rem - k;
                        if (playerDead) begin
                            if (LIVES_EN) begin
                                m_lives = m_lives - 1; m_ticks = 0;
                                m_phase = (m_lives == 0) ? 5 : 3;
                            end else begin
                                m_phase = 5;
                            end
                        end
                    end
                end
                2: if (slowClk) begin
                    m_ticks = m_ticks + 1;
                    if (m_ticks == 120) begin m_level = m_level + 1; m_load = 1; m_phase = 1; end
                end
                3: if (slowClk) begin
                    m_ticks = m_ticks + 1;
                    if (m_ticks == 60) m_phase = 1;
                end
                default: if (rise) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(currentGameState), m_load ? 1 : m_phase);
            chk("pause", int'(pause), int'(m_load || m_phase != 1));
            chk("start_screen", int'(start_screen), int'(!m_load && m_phase == 0));
            chk("death_screen", int'(death_screen), int'(m_phase == 5));
            chk("victory_screen", int'(victory_screen), int'(m_phase == 4));
            chk("newLevel", int'(newLevel), int'(m_load));
            chk("level", int'(level), m_level);
            chk("enemiesRemaining", int'(enemiesRemaining), m_rem);
            chk("livesLeft", int'(livesLeft), LIVES_EN ? m_lives : 1);
            chk("curEnemySpeed", int'(curEnemySpeed), speed_for(m_level));
            chk("tree_count", int'(tree_count), 8);
        end
    end

    initial begin
        step(2);
        chk_en = 1'b1;
        chk("rst_state", int'(currentGameState), 0);
        chk("rst_pause", int'(pause), 1);
        chk("rst_start_screen", int'(start_screen), 1);
        chk("rst_newLevel", int'(newLevel), 0);
        chk("rst_lives", int'(livesLeft), LIVES_EN ? 3 : 1);
        reset = 1'b0;
        step();

        // Start with the button held: exactly one start
        playerTrigger = 1'b1;
        step();
        chk("load_newLevel", int'(newLevel), 1);
        chk("load_pause", int'(pause), 1);
        chk("load_speed", int'(curEnemySpeed), 120);
        chk("load_trees", int'(tree_count), 8);
        step();
        chk("play_rem", int'(enemiesRemaining), 2);
        chk("play_pause", int'(pause), 0);
        step(5);
        chk("held_no_restart", int'(currentGameState), 1);
        playerTrigger = 1'b0;

        // Level 0 cleared in one shot, entry-cycle tick counts
        shot = 4'b0011; step(); shot = '0;
        chk("l0_cleared_rem", int'(enemiesRemaining), 0);
        chk("l0_transition", int'(currentGameState), 2);
        slowClk = 1'b1; step(119);
        chk("t119_still_trans", int'(currentGameState), 2);
        step();
        chk("t120_newLevel", int'(newLevel), 1);
        chk("t120_level", int'(level), 1);
        slowClk = 1'b0; step();
        chk("l1_rem", int'(enemiesRemaining), 3);
        chk("l1_speed", int'(curEnemySpeed), 240);

        // Level 1 in two volleys, then gated ticks
        shot = 4'b0001; step(); shot = 4'b0110; step(); shot = '0;
        chk("l1_cleared", int'(currentGameState), 2);
        for (int i = 0; i < 120; i++) begin
            slowClk = 1'b1; step(); slowClk = 1'b0; step(2);
        end
        step();
        chk("l2_rem", int'(enemiesRemaining), 4);

        shot = 4'b1111; step(); shot = '0;
        for (int i = 0; i < 120; i++) begin
            slowClk = 1'b1; step(); slowClk = 1'b0; step();
        end
        step();
        chk("l3_level", int'(level), 3);
        chk("l3_rem_sat", int'(enemiesRemaining), 4);
        chk("l3_speed", int'(curEnemySpeed), 480);

        shot = 4'b0111; step(); shot = '0;
        chk("l3_partial", int'(enemiesRemaining), 1);
        if (LIVES_EN) begin
            for (int d = 0; d < 2; d++) begin
                playerDead = 1'b1; step(); playerDead = 1'b0;
                chk("respawn_state", int'(currentGameState), 3);
                chk("respawn_lives", int'(livesLeft), 2 - d);
                slowClk = 1'b1; step(60); slowClk = 1'b0;
                chk("respawn_back_play", int'(currentGameState), 1);
                chk("respawn_rem_kept", int'(enemiesRemaining), 1);
            end
        end

        // Last kill and death together: victory wins, lives unchanged
        shot = 4'b0001; playerDead = 1'b1; step(); shot = '0; playerDead = 1'b0;
        chk("victory_state", int'(currentGameState), 4);
        chk("victory_screen", int'(victory_screen), 1);
        chk("victory_lives", int'(livesLeft), 1);
        playerTrigger = 1'b1; step(); playerTrigger = 1'b0;
        chk("victory_to_start", int'(currentGameState), 0);
        step();

        // New game, button held through to game over
        playerTrigger = 1'b1; step(2);
        for (int i = 0; i < 8 && currentGameState != 3'd5; i++) begin
            shot = (i == 0) ? 4'b0001 : 4'b0000;
            playerDead = 1'b1; step(); playerDead = 1'b0; shot = '0;
            if (currentGameState == 3'd3) begin
                slowClk = 1'b1; step(60); slowClk = 1'b0;
            end
        end
        chk("over_state", int'(currentGameState), 5);
        chk("over_screen", int'(death_screen), 1);
        chk("over_lives", int'(livesLeft), LIVES_EN ? 0 : 1);
        chk("over_rem", int'(enemiesRemaining), 1);
        step(4);
        chk("over_held_no_restart", int'(currentGameState), 5);
        playerTrigger = 1'b0; step();
        playerTrigger = 1'b1; step(); playerTrigger = 1'b0;
        chk("over_to_start", int'(currentGameState), 0);
        step();

        // Reset in TRANSITION with the counter part-way
        playerTrigger = 1'b1; step(); playerTrigger = 1'b0; step();
        shot = 4'b0011; step(); shot = '0;
        slowClk = 1'b1; step(50);
        reset = 1'b1; step(); reset = 1'b0; slowClk = 1'b0;
        chk("mid_rst_state", int'(currentGameState), 0);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_start", int'(start_screen), 1);
        chk("mid_rst_pause", int'(pause), 1);
        playerTrigger = 1'b1; step(); playerTrigger = 1'b0; step();
        shot = 4'b0011; step(); shot = '0;
        slowClk = 1'b1; step(119);
        chk("post_rst_t119", int'(currentGameState), 2);
        step();
        chk("post_rst_t120", int'(newLevel), 1);
        slowClk = 1'b0; step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
